// File: rtl/i_q_data_fifo_if.sv
// Symbol-stream bundle between the I/Q source, the carrier stage and the
// i_q_data_fifo storage block; master drives the requests, slave the status.
interface i_q_data_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Handshake: a symbol moves in on any rising edge with new_symbol=1 and
    // i_q_data_fifo_full=0; a symbol moves out on any edge with rd_en=1 and
    // empty=0, and is presented one edge later with a single-cycle sym_valid.
    logic          new_symbol;
    logic [3:0]    i_data;
    logic [3:0]    q_data;
    logic          rd_en;
    logic          clr_err;

    logic [3:0]    i_sym;
    logic [3:0]    q_sym;
    logic          sym_valid;
    logic          i_q_data_fifo_full;
    logic          empty;
    logic          almost_full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    modport master (
        output new_symbol, i_data, q_data, rd_en, clr_err,
        input  i_sym, q_sym, sym_valid, i_q_data_fifo_full, empty,
               almost_full, count, overflow, underflow
    );

    modport slave (
        input  new_symbol, i_data, q_data, rd_en, clr_err,
        output i_sym, q_sym, sym_valid, i_q_data_fifo_full, empty,
               almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/i_q_data_fifo.sv
// Circular-buffer FIFO of 4-bit I/Q symbol pairs with registered status and
// sticky error flags. Define IQ_FIFO_ALMOST_FULL_EN to generate almost_full.
module i_q_data_fifo #(
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12
) (
    input  logic             data_clk,
    input  logic             rst_n,
    i_q_data_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 4 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 ||
        AF_THRESH < 1 || AF_THRESH >= DEPTH) begin : g_bad_params
        $error("i_q_data_fifo: DEPTH must be a power of two in 4..256 and AF_THRESH in 1..DEPTH-1");
    end

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt;
    logic          full_r;
    logic          empty_r;
    logic          af_r;
    logic [3:0]    i_sym_r;
    logic [3:0]    q_sym_r;
    logic          valid_r;
    logic          overflow_r;
    logic          underflow_r;
    logic          wr_acc;
    logic          rd_acc;
    logic          wr_drop;
    logic          rd_miss;

    // Acceptance looks only at the registered flags, so a read in the same
    // cycle never frees a slot for a write arriving while full.
    always_comb begin
        wr_acc  = bus.new_symbol & ~full_r;
        rd_acc  = bus.rd_en & ~empty_r;
        wr_drop = bus.new_symbol & full_r;
        rd_miss = bus.rd_en & empty_r;
    end

    always_comb begin
        count_nxt = count_r;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count_r + CW'(1);
            2'b01:   count_nxt = count_r - CW'(1);
            default: count_nxt = count_r;
        endcase
    end

    // Storage has no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge data_clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= {bus.i_data, bus.q_data};
        end
    end

    always_ff @(posedge data_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_r <= count_nxt;
            full_r  <= (count_nxt == CW'(DEPTH));
            empty_r <= (count_nxt == '0);
        end
    end

    // The read port samples mem before this edge's write lands, so with one
    // entry stored a simultaneous write/read returns the older symbol.
    always_ff @(posedge data_clk or negedge rst_n) begin
        if (!rst_n) begin
            i_sym_r <= '0;
            q_sym_r <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= rd_acc;
            if (rd_acc) begin
                {i_sym_r, q_sym_r} <= mem[rd_ptr];
            end
        end
    end

    // A fresh error outranks clr_err in the same cycle.
    always_ff @(posedge data_clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= wr_drop | (overflow_r & ~bus.clr_err);
            underflow_r <= rd_miss | (underflow_r & ~bus.clr_err);
        end
    end

`ifdef IQ_FIFO_ALMOST_FULL_EN
    always_ff @(posedge data_clk or negedge rst_n) begin
        if (!rst_n) begin
            af_r <= 1'b0;
        end else begin
            af_r <= (count_nxt >= CW'(AF_THRESH));
        end
    end
`else
    assign af_r = 1'b0;
`endif

    assign bus.i_sym              = i_sym_r;
    assign bus.q_sym              = q_sym_r;
    assign bus.sym_valid          = valid_r;
    assign bus.i_q_data_fifo_full = full_r;
    assign bus.empty              = empty_r;
    assign bus.almost_full        = af_r;
    assign bus.count              = count_r;
    assign bus.overflow           = overflow_r;
    assign bus.underflow          = underflow_r;
endmodule
